// File: rtl/ps2_cmd_sequencer.sv
// PS/2 host command sequencer: queues host command bytes, sends them one at a
// time to a PS/2 controller, and handles the device's FA/FE/FC responses,
// response timeouts and a bounded number of resends. Bytes that are not
// consumed as responses are passed through on rx_data/rx_valid.
module ps2_cmd_sequencer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 1000000,
    parameter int MAX_RETRY   = 2,
    parameter int AUTO_INIT   = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_cmd,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       busy,
    output logic       ovf,
    output logic [3:0] done_cnt,
    output logic [3:0] err_cnt,
    output logic [7:0] ps2_cmd,
    output logic       ps2_send,
    input  logic       ps2_sent,
    input  logic       ps2_timeout,
    input  logic [7:0] ps2_rx,
    input  logic       ps2_rx_en,
    output logic [7:0] rx_data,
    output logic       rx_valid
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_RESEND = 8'hFE;
    localparam logic [7:0] RSP_ERROR  = 8'hFC;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_SENT,
        WAIT_ACK,
        RETRY
    } state_t;

    state_t           state, state_nxt;
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic [TMR_W-1:0] ack_tmr;
    logic [RTY_W-1:0] rty_cnt;
    logic             push, pop;
    logic             latch_cmd, rty_inc, done_inc, err_inc, rx_fwd;
    logic             vld_p1;
    logic [7:0]       rx_data_p1;

    assign full     = (count == CNT_FULL);
    assign push     = wr_cmd && !full;
    assign busy     = (state != IDLE) || (count != '0);
    assign ps2_send = (state == SEND);
    assign rx_valid = vld_p1;
    assign rx_data  = rx_data_p1;

    // Queue storage; reset preloads the FF (reset) / F4 (enable) pair when AUTO_INIT is set.
    always_ff @(posedge clock) begin
        if (reset) begin
            if (AUTO_INIT != 0) begin
                fifo_mem[0] <= 8'hFF;
                fifo_mem[1] <= 8'hF4;
            end
        end else if (push) begin
            fifo_mem[wr_ptr] <= wr_data;
        end
    end

    // Queue pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= (AUTO_INIT != 0) ? PTR_W'(2) : '0;
            count  <= (AUTO_INIT != 0) ? CNT_W'(2) : '0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_cmd && full) ovf <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode, response classification and pop/count strobes.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        latch_cmd = 1'b0;
        rty_inc   = 1'b0;
        done_inc  = 1'b0;
        err_inc   = 1'b0;
        rx_fwd    = ps2_rx_en;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    latch_cmd = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: state_nxt = WAIT_SENT;
            WAIT_SENT: begin
                if (ps2_timeout)   state_nxt = RETRY;
                else if (ps2_sent) state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ps2_rx_en && ps2_rx == RSP_ACK) begin
                    rx_fwd    = 1'b0;
                    pop       = 1'b1;
                    done_inc  = 1'b1;
                    state_nxt = IDLE;
                end else if (ps2_rx_en && ps2_rx == RSP_RESEND) begin
                    rx_fwd    = 1'b0;
                    state_nxt = RETRY;
                end else if (ps2_rx_en && ps2_rx == RSP_ERROR) begin
                    rx_fwd    = 1'b0;
                    pop       = 1'b1;
                    err_inc   = 1'b1;
                    state_nxt = IDLE;
                end else if (ack_tmr == TMR_LAST) begin
                    // Unrelated bytes are still forwarded; they do not count as a response.
                    state_nxt = RETRY;
                end
            end
            RETRY: begin
                if (rty_cnt < RTY_MAX) begin
                    rty_inc   = 1'b1;
                    state_nxt = SEND;
                end else begin
                    pop       = 1'b1;
                    err_inc   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Response timer runs only in WAIT_ACK, so it is zero on every entry.
    always_ff @(posedge clock) begin
        if (reset || state != WAIT_ACK) ack_tmr <= '0;
        else                            ack_tmr <= ack_tmr + 1'b1;
    end

    // Retry count per command; cleared whenever the head leaves the queue.
    always_ff @(posedge clock) begin
        if (reset || pop) rty_cnt <= '0;
        else if (rty_inc) rty_cnt <= rty_cnt + 1'b1;
    end

    // Command byte held for the controller plus completion/abandon counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            ps2_cmd  <= 8'h00;
            done_cnt <= 4'd0;
            err_cnt  <= 4'd0;
        end else begin
            if (latch_cmd) ps2_cmd  <= fifo_mem[rd_ptr];
            if (done_inc)  done_cnt <= done_cnt + 1'b1;
            if (err_inc)   err_cnt  <= err_cnt + 1'b1;
        end
    end

    // Stage p1: passthrough bytes appear one cycle after their receive strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1     <= 1'b0;
            rx_data_p1 <= 8'h00;
        end else begin
            vld_p1 <= rx_fwd;
            if (rx_fwd) rx_data_p1 <= ps2_rx;
        end
    end

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Randomized bench: the bench plays host and PS/2 device, keeps the expected
// queue contents, counters and passthrough bytes, and checks the sequencer.
module tb_ps2_cmd_sequencer;

    localparam int FIFO_DEPTH  = 4;
    localparam int ACK_TIMEOUT = 16;
    localparam int MAX_RETRY   = 2;
    localparam int N_CMDS      = 48;
    localparam int BURST_IDX   = 5;
    localparam int RST_IDX     = 20;

    logic       clock = 1'b0;
    logic       reset;
    logic       wr_cmd;
    logic [7:0] wr_data;
    logic       full, busy, ovf;
    logic [3:0] done_cnt, err_cnt;
    logic [7:0] ps2_cmd;
    logic       ps2_send;
    logic       ps2_sent, ps2_timeout;
    logic [7:0] ps2_rx;
    logic       ps2_rx_en;
    logic [7:0] rx_data;
    logic       rx_valid;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;

    logic [7:0]  q[$];          // expected queue contents, head first
    int unsigned fwd_due[$];    // cycle at which each passthrough byte must appear
    logic [7:0]  fwd_byte[$];
    logic [3:0]  exp_done, exp_err;
    logic        exp_ovf;
    bit          pop_now, wr_force, no_wr;

    ps2_cmd_sequencer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .MAX_RETRY  (MAX_RETRY),
        .AUTO_INIT  (1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .wr_cmd     (wr_cmd),
        .wr_data    (wr_data),
        .full       (full),
        .busy       (busy),
        .ovf        (ovf),
        .done_cnt   (done_cnt),
        .err_cnt    (err_cnt),
        .ps2_cmd    (ps2_cmd),
        .ps2_send   (ps2_send),
        .ps2_sent   (ps2_sent),
        .ps2_timeout(ps2_timeout),
        .ps2_rx     (ps2_rx),
        .ps2_rx_en  (ps2_rx_en),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Passthrough monitor: every expected byte exactly on its due cycle, nothing else.
    always @(negedge clock) begin
        if (fwd_due.size() > 0 && fwd_due[0] <= cyc) begin
            check("rx_valid", rx_valid, 1);
            check("rx_data", rx_data, fwd_byte[0]);
            void'(fwd_due.pop_front());
            void'(fwd_byte.pop_front());
        end else if (rx_valid === 1'b1) begin
            check("rx_spurious", rx_valid, 0);
        end
    end

    task automatic push_fwd(input logic [7:0] b);
        fwd_due.push_back(cyc + 1);
        fwd_byte.push_back(b);
    endtask

    // One clock: optional host write, scheduled head pop, then clear strobes.
    task automatic tick();
        logic [7:0] b;
        if (wr_force || (!no_wr && q.size() < FIFO_DEPTH &&
                         $urandom_range(0, 99) < ((q.size() == 0) ? 30 : 5))) begin
            b       = 8'($urandom);
            wr_cmd  = 1'b1;
            wr_data = b;
            if (q.size() >= FIFO_DEPTH) exp_ovf = 1'b1;
            else                        q.push_back(b);
        end
        if (pop_now) begin
            void'(q.pop_front());
            pop_now = 1'b0;
        end
        @(negedge clock);
        wr_cmd      = 1'b0;
        ps2_sent    = 1'b0;
        ps2_timeout = 1'b0;
        ps2_rx_en   = 1'b0;
    endtask

    function automatic logic [7:0] other_byte();
        logic [7:0] b;
        do b = 8'($urandom); while (b == 8'hFA || b == 8'hFE || b == 8'hFC);
        return b;
    endfunction

    // Idle sequencer: a queued head is sent next cycle; a write into an empty
    // queue is sent two cycles after the write strobe.
    task automatic wait_send(output bit ok);
        int exp_at;
        bit was_empty;
        exp_at = -1;
        ok     = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (ps2_send === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (exp_at < 0 && q.size() > 0) exp_at = int'(cyc) + 1;
            was_empty = (q.size() == 0);
            tick();
            if (was_empty && q.size() > 0) exp_at = int'(cyc) + 1;
        end
        if (!ok) check("send_seen", 0, 1);
        else     check("send_cycle", cyc, exp_at);
    endtask

    task automatic finish_cmd();
        check("done_cnt", done_cnt, exp_done);
        check("err_cnt", err_cnt, exp_err);
        check("ovf", ovf, exp_ovf);
        check("full", full, q.size() == FIFO_DEPTH);
        check("busy", busy, q.size() != 0);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        wr_cmd    = 1'b1;
        wr_data   = 8'h55;
        ps2_rx    = 8'hFA;
        ps2_rx_en = 1'b1;
        ps2_sent  = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("rst_send", ps2_send, 0);
        check("rst_cmd", ps2_cmd, 8'h00);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_ovf", ovf, 0);
        check("rst_done", done_cnt, 0);
        check("rst_err", err_cnt, 0);
        check("rst_full", full, 0);
        check("rst_busy", busy, 1);
        wr_cmd    = 1'b0;
        ps2_rx_en = 1'b0;
        ps2_sent  = 1'b0;
        reset     = 1'b0;
        q         = {8'hFF, 8'hF4};
        exp_done  = 4'd0;
        exp_err   = 4'd0;
        exp_ovf   = 1'b0;
        pop_now   = 1'b0;
    endtask

    // Play the device for one queued command until it is acknowledged or abandoned.
    task automatic run_cmd(input int idx);
        bit         ok;
        int         tries;
        int         d;
        int         kind;
        logic [7:0] cur;
        logic [7:0] b;
        tries = 0;
        wait_send(ok);
        if (!ok) return;
        cur = q[0];
        forever begin
            check("ps2_cmd", ps2_cmd, cur);
            tick();
            check("send_pulse", ps2_send, 0);
            if (idx == BURST_IDX && tries == 0) begin
                wr_force = 1'b1;
                repeat (5) tick();
                wr_force = 1'b0;
                check("burst_full", full, 1);
                check("burst_ovf", ovf, 1);
                check("burst_cmd", ps2_cmd, cur);
                check("burst_busy", busy, 1);
            end
            d = $urandom_range(1, 5);
            for (int i = 0; i < d; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    b         = 8'($urandom);
                    ps2_rx    = b;
                    ps2_rx_en = 1'b1;
                    push_fwd(b);
                end
                tick();
            end
            if ($urandom_range(0, 9) == 0) begin
                ps2_timeout = 1'b1;
                ps2_sent    = 1'($urandom_range(0, 1));
                tick();
            end else begin
                ps2_sent = 1'b1;
                tick();
                if (idx == RST_IDX) begin
                    do_reset();
                    return;
                end
                kind = $urandom_range(0, 99);
                if (kind < 12) begin
                    // No response: all ACK_TIMEOUT waiting cycles elapse, then the retry decision.
                    repeat (ACK_TIMEOUT) tick();
                end else begin
                    d = $urandom_range(0, 4);
                    for (int i = 0; i < d; i++) begin
                        if ($urandom_range(0, 2) == 0) begin
                            b         = other_byte();
                            ps2_rx    = b;
                            ps2_rx_en = 1'b1;
                            push_fwd(b);
                        end
                        tick();
                    end
                    ps2_rx_en = 1'b1;
                    if (kind < 62) begin
                        ps2_rx  = 8'hFA;
                        pop_now = 1'b1;
                        exp_done++;
                        tick();
                        finish_cmd();
                        return;
                    end else if (kind < 72) begin
                        ps2_rx  = 8'hFC;
                        pop_now = 1'b1;
                        exp_err++;
                        tick();
                        finish_cmd();
                        return;
                    end else begin
                        ps2_rx = 8'hFE;
                        tick();
                    end
                end
            end
            // Retry decision cycle: received bytes here are passthrough, even FA.
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0:       b = 8'hFA;
                    1:       b = 8'hFE;
                    2:       b = 8'hFC;
                    default: b = 8'($urandom);
                endcase
                ps2_rx    = b;
                ps2_rx_en = 1'b1;
                push_fwd(b);
            end
            if (tries < MAX_RETRY) begin
                tries++;
                tick();
                check("resend", ps2_send, 1);
            end else begin
                pop_now = 1'b1;
                exp_err++;
                tick();
                finish_cmd();
                return;
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        wr_cmd      = 1'b0;
        wr_data     = 8'h00;
        ps2_sent    = 1'b0;
        ps2_timeout = 1'b0;
        ps2_rx      = 8'h00;
        ps2_rx_en   = 1'b0;
        pop_now     = 1'b0;
        wr_force    = 1'b0;
        no_wr       = 1'b0;
        exp_done    = 4'd0;
        exp_err     = 4'd0;
        exp_ovf     = 1'b0;
        do_reset();
        for (int i = 0; i < N_CMDS; i++) run_cmd(i);
        no_wr = 1'b1;
        for (int g = 0; g < 20 && q.size() > 0; g++) run_cmd(-1);
        repeat (4) tick();
        check("final_busy", busy, 0);
        check("final_fwd_left", fwd_due.size(), 0);
        check("final_done", done_cnt, exp_done);
        check("final_err", err_cnt, exp_err);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
